// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the MEM/WB pipeline. Commits the *_Wr bundle into a
//   32 x 32-bit general register file with per-byte write lanes. Two
//   combinational read ports feed decode and see the committing value in the
//   same cycle (write-through bypass of the merged word). A commit counter
//   tracks retired register writes.
//
// Ports
//   clk                  clock, all state updates on posedge
//   rst_n                synchronous active-low reset (clears regs and counter)
//   MemData_Wr           load data from MEM/WB
//   Rd_write_byte_en_Wr  byte-lane write enables, bit i -> bits [8i+7:8i]
//   WBData_Wr            ALU/link result from MEM/WB
//   MemRead_Wr           1 selects MemData_Wr as write source, 0 WBData_Wr
//   RegWrite_Wr          register write request
//   Rd_Wr                destination register index
//   Rs_addr / Rt_addr    read port A / B index
//   Rs_data / Rt_data    read port A / B data (combinational, r0 reads 0)
//   WB_result            merged word committed this cycle (for forwarding)
//   WB_valid             1 when a commit happens this cycle
//   Commit_Cnt           commits since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      MemData_Wr,
  input  logic [3:0]       Rd_write_byte_en_Wr,
  input  logic [31:0]      WBData_Wr,
  input  logic             MemRead_Wr,
  input  logic             RegWrite_Wr,
  input  logic [4:0]       Rd_Wr,
  input  logic [4:0]       Rs_addr,
  input  logic [4:0]       Rt_addr,
  output logic [31:0]      Rs_data,
  output logic [31:0]      Rt_data,
  output logic [31:0]      WB_result,
  output logic             WB_valid,
  output logic [CNT_W-1:0] Commit_Cnt
);

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [32];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] merged;
  logic              we;

  // Byte-lane merge: enabled lanes take the new data, the rest keep the old word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] new_w,
    input logic [DATA_W-1:0] old_w,
    input logic [LANES-1:0]  be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Read with r0 hard-wired to zero and same-cycle bypass of the committing word.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic              wr_en,
    input logic [4:0]        wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    if (addr == 5'd0)                  r = '0;
    else if (wr_en && addr == wr_addr) r = wr_data;
    else                               r = stored;
    return r;
  endfunction

  always_comb begin
    src    = MemRead_Wr ? MemData_Wr : WBData_Wr;
    // rst_n gates the commit so a reset cycle never reports or bypasses a write.
    we     = rst_n && RegWrite_Wr && (Rd_Wr != 5'd0) && (Rd_write_byte_en_Wr != 4'd0);
    merged = merge_lanes(src, regs_q[Rd_Wr], Rd_write_byte_en_Wr);
    cnt_d  = we ? cnt_q + 1'b1 : cnt_q;
  end

  assign WB_result  = merged;
  assign WB_valid   = we;
  assign Commit_Cnt = cnt_q;
  assign Rs_data    = read_port(Rs_addr, we, Rd_Wr, merged, regs_q[Rs_addr]);
  assign Rt_data    = read_port(Rt_addr, we, Rd_Wr, merged, regs_q[Rt_addr]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      // we already excludes Rd_Wr == 0, so r0 stays zero.
      if (we) regs_q[Rd_Wr] <= merged;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      MemData_Wr = '0;
  logic [3:0]       Rd_write_byte_en_Wr = '0;
  logic [31:0]      WBData_Wr = '0;
  logic             MemRead_Wr = 1'b0;
  logic             RegWrite_Wr = 1'b0;
  logic [4:0]       Rd_Wr = '0;
  logic [4:0]       Rs_addr = '0;
  logic [4:0]       Rt_addr = '0;
  logic [31:0]      Rs_data, Rt_data, WB_result;
  logic             WB_valid;
  logic [CNT_W-1:0] Commit_Cnt;

  wb_regfile #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemData_Wr(MemData_Wr), .Rd_write_byte_en_Wr(Rd_write_byte_en_Wr),
    .WBData_Wr(WBData_Wr), .MemRead_Wr(MemRead_Wr), .RegWrite_Wr(RegWrite_Wr),
    .Rd_Wr(Rd_Wr), .Rs_addr(Rs_addr), .Rt_addr(Rt_addr),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .WB_result(WB_result),
    .WB_valid(WB_valid), .Commit_Cnt(Commit_Cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    logic [31:0] res;
    logic [31:0] rs;
    logic [31:0] rt;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: register contents and commit count, as plain arrays/ints.
  int unsigned ref_regs [32];
  int          ref_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input int addr, input bit we, input int rd,
                                           input logic [31:0] wval);
    if (addr == 0) return 32'd0;
    if (we && addr == rd) return wval;
    return ref_regs[addr];
  endfunction

  // One cycle of stimulus: drive after the edge, push the expected response.
  task automatic step(input bit rst_b, input bit rw, input int rd, input bit mr,
                      input logic [31:0] md, input logic [31:0] wd, input logic [3:0] be,
                      input int rs, input int rt);
    exp_t        e;
    logic [31:0] src, mrg, mask;
    bit          we;
    @(posedge clk); #1;
    rst_n = rst_b; RegWrite_Wr = rw; Rd_Wr = rd[4:0]; MemRead_Wr = mr;
    MemData_Wr = md; WBData_Wr = wd; Rd_write_byte_en_Wr = be;
    Rs_addr = rs[4:0]; Rt_addr = rt[4:0];
    src = mr ? md : wd;
    we  = rst_b && rw && (rd != 0) && (be != 0);
    mrg = 32'd0;
    for (int i = 0; i < 4; i++) begin
      mask = 32'hFF << (8 * i);
      mrg  = mrg | ((be[i] ? src : ref_regs[rd]) & mask);
    end
    e.vld = we;
    e.res = mrg;
    e.rs  = ref_read(rs, we, rd, mrg);
    e.rt  = ref_read(rt, we, rd, mrg);
    e.cnt = ref_cnt;
    exp_q.push_back(e);
    if (!rst_b) begin
      foreach (ref_regs[i]) ref_regs[i] = 0;
      ref_cnt = 0;
    end else if (we) begin
      ref_regs[rd] = mrg;
      ref_cnt = (ref_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic rd2(input int rs, input int rt);
    step(1, 0, 0, 0, 32'd0, 32'd0, 4'h0, rs, rt);
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("WB_valid", {31'd0, WB_valid}, {31'd0, e.vld});
        if (e.vld) chk("WB_result", WB_result, e.res);
        chk("Rs_data", Rs_data, e.rs);
        chk("Rt_data", Rt_data, e.rt);
        chk("Commit_Cnt", {{(32-CNT_W){1'b0}}, Commit_Cnt}, e.cnt[31:0]);
      end
    end
  end

  initial begin
    foreach (ref_regs[i]) ref_regs[i] = 0;
    // Reset held one cycle, then every register read back.
    step(0, 0, 0, 0, 32'd0, 32'd0, 4'h0, 0, 0);
    for (int i = 0; i < 32; i++) rd2(i, 31 - i);
    // Full-word write with same-cycle bypass, then from the array.
    step(1, 1, 5, 0, 32'h0, 32'hDEADBEEF, 4'hF, 5, 5);
    rd2(5, 0);
    // Partial load write merges with the old word.
    step(1, 1, 5, 1, 32'h11223344, 32'h0, 4'b0011, 5, 5);
    rd2(5, 5);
    // Empty byte mask: no commit.
    step(1, 1, 5, 1, 32'hCAFEF00D, 32'h0, 4'b0000, 5, 5);
    rd2(5, 5);
    // r0 writes are dropped and r0 reads zero.
    step(1, 1, 0, 0, 32'h0, 32'hFFFFFFFF, 4'hF, 0, 0);
    rd2(0, 0);
    // Write coincident with reset is discarded.
    step(1, 1, 7, 0, 32'h0, 32'h12345678, 4'hF, 7, 5);
    step(0, 1, 7, 0, 32'h0, 32'hA5A5A5A5, 4'hF, 7, 7);
    rd2(7, 5);
    // 17 back-to-back commits wrap the 4-bit counter to 1.
    for (int k = 0; k < 17; k++)
      step(1, 1, 1 + (k % 31), 0, 32'h0, $urandom, 4'hF, 1 + (k % 31), 31 - (k % 31));
    rd2(1, 17);
    // Randomized traffic with occasional resets and biased read addresses.
    for (int k = 0; k < 400; k++) begin
      int rd, rs, rt;
      rd = $urandom_range(0, 31);
      rs = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, 31);
      rt = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, 31);
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), rd,
           $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)), rs, rt);
    end
    rd2(0, 0);
    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
